// File: rtl/conv_job_sequencer_pkg.sv
// Shared definitions for the convolution job sequencer: FSM encoding and default sizing.
package conv_job_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam int DEF_ID_W    = 4;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 256;
  localparam int DEF_CNT_W   = 9;

endpackage

// File: rtl/conv_job_sequencer_if.sv
// Signal bundle between host, sequencer, convolution controller and result consumer.
interface conv_job_sequencer_if #(
  parameter int ID_W  = 4,
  parameter int CNT_W = 9
) ();
  // Handshakes: a transfer happens at a rising edge where valid && ready are both high.
  // valid must not depend on ready; payload is held stable while valid is high and ready is low.
  logic             job_valid;
  logic             job_ready;
  logic [ID_W-1:0]  job_id;
  logic             conv_start;
  logic             conv_done;
  logic             result_valid;
  logic             result_ready;
  logic [ID_W-1:0]  result_id;
  logic             result_timeout;
  logic [CNT_W-1:0] result_cycles;
  logic             busy;
  logic             err_stray_done;

  modport slave (
    input  job_valid, job_id, conv_done, result_ready,
    output job_ready, conv_start, result_valid, result_id, result_timeout,
           result_cycles, busy, err_stray_done
  );

  modport master (
    output job_valid, job_id, conv_done, result_ready,
    input  job_ready, conv_start, result_valid, result_id, result_timeout,
           result_cycles, busy, err_stray_done
  );
endinterface

// File: rtl/conv_job_fifo.sv
// DEPTH x W synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module conv_job_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/conv_job_sequencer.sv
// Queues job IDs, launches each with a one-cycle conv_start, then reports ID, outcome
// and elapsed WAIT cycles on the result port.
module conv_job_sequencer
  import conv_job_sequencer_pkg::*;
#(
  parameter int ID_W    = DEF_ID_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_job_sequencer_if.slave  bus,
  output state_t               dbg_state
);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  fifo_dout;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] res_cycles;
  logic             res_timeout;
  logic             done_q;
  logic             stray_err;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             done_evt;
  logic             cnt_hit;

  assign cnt_inc  = cnt + 1'b1;
  assign cnt_hit  = (cnt_inc == TO_CNT);
  // A done held high over several cycles is one event.
  assign done_evt = bus.conv_done && !done_q;
  assign push     = bus.job_valid && !fifo_full;

  conv_job_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.job_id),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done_evt || cnt_hit) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        if (bus.result_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_id      <= '0;
      cnt         <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
      done_q      <= 1'b0;
      stray_err   <= 1'b0;
    end else begin
      done_q <= bus.conv_done;
      if (done_evt && state != ST_WAIT) stray_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_id <= fifo_dout;
            cnt    <= '0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt_inc;
          // Completion takes priority over a timeout landing on the same cycle.
          if (done_evt) begin
            res_timeout <= 1'b0;
            res_cycles  <= cnt_inc;
          end else if (cnt_hit) begin
            res_timeout <= 1'b1;
            res_cycles  <= TO_CNT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.job_ready      = !fifo_full;
  assign bus.conv_start     = (state == ST_LAUNCH);
  assign bus.result_valid   = (state == ST_REPORT);
  assign bus.result_id      = cur_id;
  assign bus.result_timeout = res_timeout;
  assign bus.result_cycles  = res_cycles;
  assign bus.busy           = (state != ST_IDLE) || !fifo_empty;
  assign bus.err_stray_done = stray_err;
  assign dbg_state          = state;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Bench for conv_job_sequencer: vector table plus hand-written queueing, stray-done and reset sequences.
module tb_conv_job_sequencer;
  import conv_job_sequencer_pkg::*;

  localparam int ID_W    = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 9;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  logic   force_done;
  int     starts;
  int     cd;
  int     n_vec;
  int     n_bad;

  logic [13:0] exp_q[$];   // {id, timeout, cycles}
  int          dly_q[$];   // conv_done delay per launched job, 0 = never

  typedef struct {
    logic [3:0] id;
    int         dly;
    int         stall;
    logic       exp_to;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[6];

  conv_job_sequencer_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  conv_job_sequencer #(
    .ID_W    (ID_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Convolution controller model: pulses conv_done a fixed delay after conv_start.
  always @(negedge clk) begin
    bus.conv_done = force_done;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) bus.conv_done = 1'b1;
    end
    if (bus.conv_start && dly_q.size() > 0) cd = dly_q.pop_front();
  end

  always @(negedge clk) begin
    if (bus.conv_start) starts = starts + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec = n_vec + 1;
    n_bad = n_bad + 1;
    $display("FAIL %s: bounded wait expired at %0t", name, $time);
  endtask

  // driver: offer one job, hold until accepted; records its expected result
  task automatic push_job(input logic [3:0] id, input int dly, input logic to, input int cyc);
    int guard;
    bus.job_valid = 1'b1;
    bus.job_id    = id;
    guard = 0;
    while (!bus.job_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.job_ready) fail_now("job_accept");
    @(negedge clk);
    bus.job_valid = 1'b0;
    dly_q.push_back(dly);
    exp_q.push_back({id, to, 9'(cyc)});
  endtask

  // scoreboard: wait for a result, optionally stall, compare and handshake
  task automatic wait_result(input int stall);
    int          guard;
    logic [13:0] e;
    guard = 0;
    while (!bus.result_valid && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.result_valid) begin
      fail_now("result_wait");
      return;
    end
    if (exp_q.size() == 0) begin
      fail_now("unexpected_result");
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < stall; k++) begin
      check("stall_id", 32'(bus.result_id), 32'(e[13:10]));
      check("stall_cycles", 32'(bus.result_cycles), 32'(e[8:0]));
      check("stall_no_start", 32'(bus.conv_start), 0);
      @(negedge clk);
    end
    check("res_valid", 32'(bus.result_valid), 1);
    check("res_id", 32'(bus.result_id), 32'(e[13:10]));
    check("res_timeout", 32'(bus.result_timeout), 32'(e[9]));
    check("res_cycles", 32'(bus.result_cycles), 32'(e[8:0]));
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'd5,  10, 0, 1'b0, 10};
    vecs[1] = '{4'd10,  0, 0, 1'b1, 16};
    vecs[2] = '{4'd3,   1, 5, 1'b0, 1};
    vecs[3] = '{4'd15, 16, 0, 1'b0, 16};
    vecs[4] = '{4'd7,  15, 2, 1'b0, 15};
    vecs[5] = '{4'd0,   0, 1, 1'b1, 16};

    n_vec = 0;
    n_bad = 0;
    starts = 0;
    cd = 0;
    force_done = 1'b0;
    rst_n = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_id = '0;
    bus.result_ready = 1'b0;
    bus.conv_done = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_job_ready", 32'(bus.job_ready), 1);
    check("rst_conv_start", 32'(bus.conv_start), 0);
    check("rst_result_valid", 32'(bus.result_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(bus.err_stray_done), 0);
    check("rst_result_id", 32'(bus.result_id), 0);
    check("rst_result_cycles", 32'(bus.result_cycles), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single jobs: done delay, timeout, stalled consumer, done on the timeout cycle
    for (int i = 0; i < 6; i++) begin
      push_job(vecs[i].id, vecs[i].dly, vecs[i].exp_to, vecs[i].exp_cyc);
      wait_result(vecs[i].stall);
      check("starts_per_job", 32'(starts), 32'(i + 1));
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_valid", 32'(bus.result_valid), 0);
    end
    check("no_stray_yet", 32'(bus.err_stray_done), 0);

    // conv_done while idle is only flagged
    @(posedge clk);
    #1 force_done = 1'b1;
    @(posedge clk);
    #1 force_done = 1'b0;
    @(negedge clk);
    check("stray_set", 32'(bus.err_stray_done), 1);
    check("stray_state", 32'(dbg_state), 32'(ST_IDLE));
    check("stray_busy", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    check("stray_sticky", 32'(bus.err_stray_done), 1);

    // five back-to-back jobs into a four-deep queue
    for (int i = 1; i <= 5; i++) push_job(4'(i), 2, 1'b0, 2);
    check("full_ready", 32'(bus.job_ready), 0);
    check("full_busy", 32'(bus.busy), 1);
    wait_result(4);
    @(negedge clk);
    check("ready_after_pop", 32'(bus.job_ready), 1);
    for (int i = 2; i <= 5; i++) wait_result(0);
    check("queue_starts", 32'(starts), 11);

    // reset in the middle of WAIT with another job still queued
    push_job(4'd9, 0, 1'b1, 16);
    push_job(4'd11, 3, 1'b0, 3);
    repeat (6) @(negedge clk);
    check("pre_rst_state", 32'(dbg_state), 32'(ST_WAIT));
    check("pre_rst_ready_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_ready", 32'(bus.job_ready), 1);
    check("arst_err", 32'(bus.err_stray_done), 0);
    check("arst_conv_start", 32'(bus.conv_start), 0);
    exp_q.delete();
    dly_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_start_none", 32'(bus.conv_start), 0);
    push_job(4'd12, 4, 1'b0, 4);
    wait_result(0);
    check("post_rst_starts", 32'(starts), 13);
    check("post_rst_busy", 32'(bus.busy), 0);
    check("leftover_expected", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
